// File: rtl/ahb_cmd_arbiter.sv
// Two-requester round-robin arbiter for the AHB master command port.
// A grant is held for a whole burst, including the return of all of its read data.
module ahb_cmd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int INCR_BEATS = 16
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  m0_vld_i,
    output logic                  m0_rdy_o,
    input  logic                  m0_wr_en_i,
    input  logic                  m0_rd_en_i,
    input  logic [2:0]            m0_size_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [31:0]           m0_wdata_i,
    input  logic [2:0]            m0_burst_i,
    output logic                  m0_dout_vld_o,
    output logic [31:0]           m0_rdata_o,
    input  logic                  m0_dout_rdy_i,
    input  logic                  m1_vld_i,
    output logic                  m1_rdy_o,
    input  logic                  m1_wr_en_i,
    input  logic                  m1_rd_en_i,
    input  logic [2:0]            m1_size_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [31:0]           m1_wdata_i,
    input  logic [2:0]            m1_burst_i,
    output logic                  m1_dout_vld_o,
    output logic [31:0]           m1_rdata_o,
    input  logic                  m1_dout_rdy_i,
    output logic                  din_vld_o,
    input  logic                  din_rdy_i,
    output logic                  wr_en_o,
    output logic                  rd_en_o,
    output logic [2:0]            data_size_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [31:0]           wdata_o,
    output logic [2:0]            burst_o,
    input  logic                  dout_vld_i,
    input  logic [31:0]           rdata_i,
    output logic                  dout_rdy_o,
    output logic [1:0]            grant_o
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_owner_q, last_owner_d;
    logic        started_q, started_d;
    logic        rd_flag_q, rd_flag_d;
    logic [4:0]  beats_left_q, beats_left_d;
    logic [4:0]  rd_pending_q, rd_pending_d;

    logic                  own;
    logic                  owner_sel;
    logic                  beat_phase;
    logic                  own_vld;
    logic                  own_wr;
    logic                  own_rd;
    logic [2:0]            own_size;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [31:0]           own_wdata;
    logic [2:0]            own_burst;
    logic                  own_dout_rdy;
    logic                  accept;
    logic                  first_beat;
    logic                  rd_beat;
    logic                  ret;

    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst)
            3'd0:       burst_beats = 5'd1;
            3'd1:       burst_beats = 5'(INCR_BEATS);
            3'd2, 3'd3: burst_beats = 5'd4;
            3'd4, 3'd5: burst_beats = 5'd8;
            default:    burst_beats = 5'd16;
        endcase
    endfunction

    assign own       = (state_q == OWN);
    assign owner_sel = grant_q[1];
    // Once the last beat is taken the owner may already present its next
    // command; nothing more is accepted while outstanding reads drain.
    assign beat_phase = own && (!started_q || beats_left_q != 5'd0);

    assign own_vld      = owner_sel ? m1_vld_i      : m0_vld_i;
    assign own_wr       = owner_sel ? m1_wr_en_i    : m0_wr_en_i;
    assign own_rd       = owner_sel ? m1_rd_en_i    : m0_rd_en_i;
    assign own_size     = owner_sel ? m1_size_i     : m0_size_i;
    assign own_addr     = owner_sel ? m1_addr_i     : m0_addr_i;
    assign own_wdata    = owner_sel ? m1_wdata_i    : m0_wdata_i;
    assign own_burst    = owner_sel ? m1_burst_i    : m0_burst_i;
    assign own_dout_rdy = owner_sel ? m1_dout_rdy_i : m0_dout_rdy_i;

    assign din_vld_o  = beat_phase & own_vld;
    assign accept     = din_vld_o & din_rdy_i;
    assign m0_rdy_o   = beat_phase & ~owner_sel & din_rdy_i;
    assign m1_rdy_o   = beat_phase &  owner_sel & din_rdy_i;
    assign first_beat = din_vld_o & ~started_q;

    assign wr_en_o     = first_beat & own_wr;
    assign rd_en_o     = first_beat & own_rd;
    assign data_size_o = own ? own_size  : 3'd0;
    assign addr_o      = own ? own_addr  : '0;
    assign wdata_o     = own ? own_wdata : 32'd0;
    assign burst_o     = own ? own_burst : 3'd0;

    // Stray read data while idle is acknowledged and discarded so the master never stalls.
    assign dout_rdy_o    = own ? own_dout_rdy : dout_vld_i;
    assign m0_dout_vld_o = own & ~owner_sel & dout_vld_i;
    assign m1_dout_vld_o = own &  owner_sel & dout_vld_i;
    assign m0_rdata_o    = (own & ~owner_sel) ? rdata_i : 32'd0;
    assign m1_rdata_o    = (own &  owner_sel) ? rdata_i : 32'd0;
    assign grant_o       = grant_q;

    assign rd_beat = accept & (started_q ? rd_flag_q : own_rd);
    assign ret     = own & dout_vld_i & dout_rdy_o & (rd_pending_q != 5'd0);

    always_comb begin
        rd_pending_d = rd_pending_q;
        case ({rd_beat, ret})
            2'b10:   rd_pending_d = rd_pending_q + 5'd1;
            2'b01:   rd_pending_d = rd_pending_q - 5'd1;
            default: rd_pending_d = rd_pending_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        started_d    = started_q;
        rd_flag_d    = rd_flag_q;
        beats_left_d = beats_left_q;
        case (state_q)
            IDLE: begin
                if (m0_vld_i || m1_vld_i) begin
                    state_d = OWN;
                    if (m0_vld_i && m1_vld_i)
                        grant_d = last_owner_q ? 2'b01 : 2'b10;
                    else
                        grant_d = m0_vld_i ? 2'b01 : 2'b10;
                end
            end
            default: begin
                if (accept) begin
                    started_d = 1'b1;
                    if (!started_q) begin
                        beats_left_d = burst_beats(own_burst) - 5'd1;
                        rd_flag_d    = own_rd;
                    end else begin
                        beats_left_d = beats_left_q - 5'd1;
                    end
                end
                if (started_q && beats_left_q == 5'd0 && rd_pending_q == 5'd0) begin
                    state_d      = IDLE;
                    grant_d      = 2'b00;
                    last_owner_d = owner_sel;
                    started_d    = 1'b0;
                    rd_flag_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b1;
            started_q    <= 1'b0;
            rd_flag_q    <= 1'b0;
            beats_left_q <= 5'd0;
            rd_pending_q <= 5'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            started_q    <= started_d;
            rd_flag_q    <= rd_flag_d;
            beats_left_q <= beats_left_d;
            rd_pending_q <= rd_pending_d;
        end
    end

endmodule

// File: tb/tb_ahb_cmd_arbiter.sv
// Directed bench for ahb_cmd_arbiter: hand-computed cycle-by-cycle expectations
// for single, contended, stalled, read and reset scenarios.
module tb_ahb_cmd_arbiter;

    localparam int AW = 32;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          m0_vld_i, m0_rdy_o, m0_wr_en_i, m0_rd_en_i;
    logic [2:0]    m0_size_i, m0_burst_i;
    logic [AW-1:0] m0_addr_i;
    logic [31:0]   m0_wdata_i, m0_rdata_o;
    logic          m0_dout_vld_o, m0_dout_rdy_i;
    logic          m1_vld_i, m1_rdy_o, m1_wr_en_i, m1_rd_en_i;
    logic [2:0]    m1_size_i, m1_burst_i;
    logic [AW-1:0] m1_addr_i;
    logic [31:0]   m1_wdata_i, m1_rdata_o;
    logic          m1_dout_vld_o, m1_dout_rdy_i;
    logic          din_vld_o, din_rdy_i, wr_en_o, rd_en_o;
    logic [2:0]    data_size_o, burst_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o, rdata_i;
    logic          dout_vld_i, dout_rdy_o;
    logic [1:0]    grant_o;

    int total = 0;
    int bad   = 0;

    ahb_cmd_arbiter #(.ADDR_WIDTH(AW), .INCR_BEATS(16)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m0_vld_i(m0_vld_i), .m0_rdy_o(m0_rdy_o), .m0_wr_en_i(m0_wr_en_i),
        .m0_rd_en_i(m0_rd_en_i), .m0_size_i(m0_size_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_burst_i(m0_burst_i), .m0_dout_vld_o(m0_dout_vld_o),
        .m0_rdata_o(m0_rdata_o), .m0_dout_rdy_i(m0_dout_rdy_i),
        .m1_vld_i(m1_vld_i), .m1_rdy_o(m1_rdy_o), .m1_wr_en_i(m1_wr_en_i),
        .m1_rd_en_i(m1_rd_en_i), .m1_size_i(m1_size_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_burst_i(m1_burst_i), .m1_dout_vld_o(m1_dout_vld_o),
        .m1_rdata_o(m1_rdata_o), .m1_dout_rdy_i(m1_dout_rdy_i),
        .din_vld_o(din_vld_o), .din_rdy_i(din_rdy_i), .wr_en_o(wr_en_o),
        .rd_en_o(rd_en_o), .data_size_o(data_size_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .burst_o(burst_o), .dout_vld_i(dout_vld_i),
        .rdata_i(rdata_i), .dout_rdy_o(dout_rdy_o), .grant_o(grant_o)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_vld_i = 0; m0_wr_en_i = 0; m0_rd_en_i = 0; m0_size_i = 3'd2;
        m0_addr_i = '0; m0_wdata_i = '0; m0_burst_i = 3'd0; m0_dout_rdy_i = 0;
        m1_vld_i = 0; m1_wr_en_i = 0; m1_rd_en_i = 0; m1_size_i = 3'd2;
        m1_addr_i = '0; m1_wdata_i = '0; m1_burst_i = 3'd0; m1_dout_rdy_i = 0;
        din_rdy_i = 0; dout_vld_i = 0; rdata_i = '0;
    endtask

    task automatic do_reset();
        hresetn = 0;
        clear_inputs();
        tick();
        tick();
        hresetn = 1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic [1:0] exp_g;
        do_reset();

        // Reset state
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_din_vld", din_vld_o, 0);
        chk("rst_m0_rdy", m0_rdy_o, 0);
        chk("rst_dout_rdy", dout_rdy_o, 0);
        chk("rst_addr", addr_o, 0);

        // m0 SINGLE write
        m0_vld_i = 1; m0_wr_en_i = 1; m0_addr_i = 32'h100; m0_wdata_i = 32'hA5A5A5A5;
        m0_burst_i = 3'd0; din_rdy_i = 1;
        #1;
        chk("s_arb_grant", grant_o, 2'b00);
        chk("s_arb_din_vld", din_vld_o, 0);
        chk("s_arb_m0_rdy", m0_rdy_o, 0);
        tick();
        chk("s_grant", grant_o, 2'b01);
        chk("s_din_vld", din_vld_o, 1);
        chk("s_wr_en", wr_en_o, 1);
        chk("s_addr", addr_o, 32'h100);
        chk("s_wdata", wdata_o, 32'hA5A5A5A5);
        chk("s_m0_rdy", m0_rdy_o, 1);
        tick();
        m0_vld_i = 0; m0_wr_en_i = 0;
        #1;
        chk("s_drain_grant", grant_o, 2'b01);
        chk("s_drain_din_vld", din_vld_o, 0);
        tick();
        chk("s_rel_grant", grant_o, 2'b00);

        // Both requesting SINGLE writes continuously: 01,10,01
        do_reset();
        din_rdy_i = 1;
        m0_vld_i = 1; m0_wr_en_i = 1; m0_addr_i = 32'h200; m0_burst_i = 3'd0;
        m1_vld_i = 1; m1_wr_en_i = 1; m1_addr_i = 32'h300; m1_burst_i = 3'd0;
        #1;
        for (int r = 0; r < 3; r++) begin
            exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr%0d_idle_grant", r), grant_o, 2'b00);
            tick();
            chk($sformatf("rr%0d_grant", r), grant_o, exp_g);
            chk($sformatf("rr%0d_addr", r), addr_o, (r % 2 == 0) ? 32'h200 : 32'h300);
            chk($sformatf("rr%0d_m0_rdy", r), m0_rdy_o, exp_g[0]);
            chk($sformatf("rr%0d_m1_rdy", r), m1_rdy_o, exp_g[1]);
            tick();
            chk($sformatf("rr%0d_drain_grant", r), grant_o, exp_g);
            chk($sformatf("rr%0d_drain_din_vld", r), din_vld_o, 0);
            chk($sformatf("rr%0d_drain_rdy", r), {m1_rdy_o, m0_rdy_o}, 2'b00);
            tick();
        end
        clear_inputs();
        #1;

        // m1 INCR4 write with toggling ready; m0 waits with a SINGLE (last owner m0)
        m0_vld_i = 1; m0_wr_en_i = 1; m0_addr_i = 32'h500; m0_burst_i = 3'd0;
        m1_vld_i = 1; m1_wr_en_i = 1; m1_addr_i = 32'h400; m1_burst_i = 3'd3;
        din_rdy_i = 1;
        #1;
        chk("i4_idle_grant", grant_o, 2'b00);
        tick();
        for (int k = 0; k < 7; k++) begin
            din_rdy_i = (k % 2 == 0);
            m1_wdata_i = 32'hB000 + k;
            #1;
            chk($sformatf("i4_c%0d_grant", k), grant_o, 2'b10);
            chk($sformatf("i4_c%0d_m0_rdy", k), m0_rdy_o, 0);
            chk($sformatf("i4_c%0d_m1_rdy", k), m1_rdy_o, (k % 2 == 0));
            chk($sformatf("i4_c%0d_wr_en", k), wr_en_o, (k == 0));
            tick();
        end
        m1_vld_i = 0; m1_wr_en_i = 0; din_rdy_i = 1;
        #1;
        chk("i4_drain_grant", grant_o, 2'b10);
        chk("i4_drain_din_vld", din_vld_o, 0);
        tick();
        chk("i4_idle2_grant", grant_o, 2'b00);
        tick();
        chk("i4_m0_grant", grant_o, 2'b01);
        chk("i4_m0_addr", addr_o, 32'h500);
        tick();
        m0_vld_i = 0; m0_wr_en_i = 0;
        tick();
        tick();
        chk("i4_end_grant", grant_o, 2'b00);

        // Stray read data while idle is dropped
        dout_vld_i = 1; rdata_i = 32'hDEAD;
        #1;
        chk("idle_dout_rdy", dout_rdy_o, 1);
        chk("idle_m0_dout_vld", m0_dout_vld_o, 0);
        tick();
        dout_vld_i = 0;

        // m0 INCR8 read, return stalled 3 cycles
        m0_vld_i = 1; m0_rd_en_i = 1; m0_addr_i = 32'h800; m0_burst_i = 3'd5;
        #1;
        chk("rd_idle_grant", grant_o, 2'b00);
        tick();
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rd_b%0d_din_vld", k), din_vld_o, 1);
            chk($sformatf("rd_b%0d_rd_en", k), rd_en_o, (k == 0));
            tick();
        end
        m0_vld_i = 0; m0_rd_en_i = 0;
        w = 0;
        for (int c = 0; c < 11; c++) begin
            dout_vld_i = 1;
            rdata_i = 32'hC000 + w;
            m0_dout_rdy_i = !(c >= 3 && c <= 5);
            #1;
            chk($sformatf("rd_r%0d_grant", c), grant_o, 2'b01);
            chk($sformatf("rd_r%0d_din_vld", c), din_vld_o, 0);
            chk($sformatf("rd_r%0d_dout_rdy", c), dout_rdy_o, !(c >= 3 && c <= 5));
            chk($sformatf("rd_r%0d_m0_rdata", c), m0_rdata_o, 32'hC000 + w);
            chk($sformatf("rd_r%0d_m1_dout_vld", c), m1_dout_vld_o, 0);
            chk($sformatf("rd_r%0d_m1_rdata", c), m1_rdata_o, 0);
            if (!(c >= 3 && c <= 5)) w++;
            tick();
        end
        dout_vld_i = 0; m0_dout_rdy_i = 0;
        #1;
        chk("rd_words", w, 8);
        chk("rd_drain_grant", grant_o, 2'b01);
        tick();
        chk("rd_rel_grant", grant_o, 2'b00);

        // m0 undefined-length INCR write: exactly 16 beats
        m0_vld_i = 1; m0_wr_en_i = 1; m0_addr_i = 32'h900; m0_burst_i = 3'd1; din_rdy_i = 1;
        tick();
        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("incr_b%0d_grant", k), grant_o, 2'b01);
            chk($sformatf("incr_b%0d_m0_rdy", k), m0_rdy_o, 1);
            tick();
        end
        #1;
        chk("incr_b16_m0_rdy", m0_rdy_o, 0);
        chk("incr_b16_din_vld", din_vld_o, 0);
        chk("incr_b16_grant", grant_o, 2'b01);
        m0_vld_i = 0; m0_wr_en_i = 0;
        tick();
        chk("incr_rel_grant", grant_o, 2'b00);

        // Reset mid-way through m1 WRAP8
        m1_vld_i = 1; m1_wr_en_i = 1; m1_addr_i = 32'hA00; m1_burst_i = 3'd4;
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("wr8_b%0d_m1_rdy", k), m1_rdy_o, 1);
            tick();
        end
        #1;
        chk("wr8_pre_din_vld", din_vld_o, 1);
        hresetn = 0;
        #1;
        chk("wr8_rst_grant", grant_o, 2'b00);
        chk("wr8_rst_din_vld", din_vld_o, 0);
        chk("wr8_rst_m1_rdy", m1_rdy_o, 0);
        chk("wr8_rst_addr", addr_o, 0);
        chk("wr8_rst_wr_en", wr_en_o, 0);
        tick();
        hresetn = 1;
        m0_vld_i = 1; m0_wr_en_i = 1; m0_addr_i = 32'hB00; m0_burst_i = 3'd0;
        #1;
        chk("post_rst_idle_grant", grant_o, 2'b00);
        tick();
        chk("post_rst_tie_grant", grant_o, 2'b01);
        chk("post_rst_m1_rdy", m1_rdy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_cmd_arbiter.md
Name: ahb_cmd_arbiter

Overview:
- Two-requester round-robin arbiter in front of the AHB master command interface.
- Grants one requester at a time and holds the grant for a whole burst.
- Forwards the owner's command and data beats, and routes read data back to the owner only.
- Sits between the test/DMA command sources and the AHB master's din/dout handshake ports.

Parameters:
- ADDR_WIDTH, 32, width of the address path.
- INCR_BEATS, 16, beat count assumed for undefined-length INCR bursts (1..16).

Ports:
- hclk  input  1  clock
- hresetn  input  1  reset, asynchronous, active-low
- mN_vld_i  input  1  requester N (N=0,1) beat valid; first beat carries command, later beats carry write data only
- mN_rdy_o  output  1  requester N beat accepted when vld&rdy
- mN_wr_en_i  input  1  write command
- mN_rd_en_i  input  1  read command
- mN_size_i  input  3  HSIZE encoding
- mN_addr_i  input  ADDR_WIDTH  start address
- mN_wdata_i  input  32  write data
- mN_burst_i  input  3  HBURST encoding
- mN_dout_vld_o  output  1  read data valid to requester N
- mN_rdata_o  output  32  read data to requester N
- mN_dout_rdy_i  input  1  requester N read data ready
- din_vld_o  output  1  beat valid to master
- din_rdy_i  input  1  master ready
- wr_en_o  output  1  forwarded write command
- rd_en_o  output  1  forwarded read command
- data_size_o  output  3  forwarded size
- addr_o  output  ADDR_WIDTH  forwarded address
- wdata_o  output  32  forwarded write data
- burst_o  output  3  forwarded burst
- dout_vld_i  input  1  read data valid from master
- rdata_i  input  32  read data from master
- dout_rdy_o  output  1  read data ready to master
- grant_o  output  2  one-hot current owner; 00 when idle

Behaviour:
- Reset: state IDLE, grant_o=00, last_owner=1 (m0 wins first), beat and read counters 0. All outputs 0.
- State IDLE:
  - When any mN_vld_i=1, register a grant and go to OWN next cycle. No beat is accepted in the grant cycle (1-cycle arbitration latency).
  - Both requesting: grant the requester that is not last_owner.
  - One requesting: grant it.
- State OWN:
  - Downstream outputs mux the owner's inputs.
  - din_vld_o = owner vld; owner rdy = din_rdy_i; non-owner rdy = 0.
  - wr_en_o/rd_en_o are forwarded only on the first beat; 0 on later beats.
- Beat counting:
  - On the first accepted beat, latch beats_left from the burst: SINGLE 1, INCR INCR_BEATS, WRAP4/INCR4 4, WRAP8/INCR8 8, WRAP16/INCR16 16. Latch the read flag.
  - Decrement beats_left on each accepted beat (din_vld_o & din_rdy_i).
- Read tracking:
  - rd_pending (5 bits) increments on each accepted read beat.
  - It decrements on dout_vld_i & dout_rdy_o.
  - Both in the same cycle: value unchanged.
- Read return:
  - owner dout_vld_o = dout_vld_i; owner rdata_o = rdata_i; dout_rdy_o = owner dout_rdy_i.
  - Non-owner dout_vld_o = 0, rdata_o = 0.
  - dout_vld_i while IDLE: dout_rdy_o = 1 and the data is dropped (error case, no hang).
- Release:
  - Release when beats_left==0 and rd_pending==0 after at least one accepted beat.
  - On release: go to IDLE, set last_owner = owner, grant_o = 00 in the following cycle.
  - A new grant needs a fresh arbitration cycle, so there is at least 1 idle cycle between owners.
- Ordering and stalls:
  - Owner vld low mid-burst: hold grant, no timeout.
  - Non-owner requests are held pending and never dropped.
- Reset mid-burst: immediate return to reset values; downstream vld drops asynchronously.

Test Plan:
- m0 SINGLE write, addr 0x100, data 0xA5A5A5A5, din_rdy_i=1
  -> grant_o=01 one cycle after vld.
  -> din_vld_o=1, wr_en_o=1, addr_o=0x100 for one cycle.
  -> grant_o=00 two cycles after acceptance.
- m0 and m1 both assert SINGLE writes continuously
  -> grants alternate 01, 10, 01 …
  -> m0 gets the first grant.
  -> the non-owner's rdy stays 0 throughout.
- m1 INCR4 write, din_rdy_i toggling 1,0,1,0…, m0 requesting SINGLE
  -> grant_o=10 until 4 beats are accepted.
  -> wr_en_o=1 on beat 1 only.
  -> m0 is granted afterwards.
- m0 INCR8 read; master returns 8 data words; m0_dout_rdy_i low for 3 cycles mid-stream
  -> dout_rdy_o low during the stall.
  -> m1_dout_vld_o stays 0.
  -> grant is released only after the 8th word is accepted.
- m0 INCR (undefined) write with INCR_BEATS=16
  -> grant is held for exactly 16 accepted beats, then released.
- hresetn low after 2 beats of an m1 WRAP8
  -> all outputs 0 and grant_o=00 immediately.
  -> after reset, m0 wins the tie with m1.
